nios_system_sysid_checker: RTL and testbench
============================================

// Module: nios_system_sysid_checker
// PURPOSE
//  Avalon-MM read master that interrogates the system ID slave (word 0 = ID, word 1 = timestamp).
//  Compares both words against expected values and flags a hardware/software build mismatch.
//  Sits beside the Nios II in nios_system and drives a status LED/HEX path.
//  Also provides a bring-up self-check that the control_slave path is alive.
// PARAMETERS
//  EXPECTED_ID         32'd0           expected word at address 0
//  EXPECTED_TIMESTAMP  32'd1524171360  expected word at address 1
//  TIMEOUT_CYCLES      16'd255         max cycles per read, request to readdatavalid; 1..65535
//  MAX_RETRIES         2'd3            extra attempts per word after a timeout
//  AUTO_START          1'b1            1: start one check sequence automatically after reset
// PORTS
//  clock              in   1   system clock
//  reset              in   1   synchronous, active-high reset
//  start              in   1   one-cycle pulse; begins a check when the FSM is idle or done
//  avm_address        out  1   word address: 0 = ID, 1 = timestamp
//  avm_read           out  1   Avalon read strobe
//  avm_waitrequest    in   1   slave stall; tie to 0 for a zero-wait slave
//  avm_readdata       in   32  read data
//  avm_readdatavalid  in   1   read data qualifier
//  busy               out  1   check sequence in progress
//  done               out  1   sticky; set when a sequence completes, cleared by the next start
//  id_ok              out  1   ID word matched EXPECTED_ID
//  ts_ok              out  1   timestamp word matched EXPECTED_TIMESTAMP
//  timeout_err        out  1   retries exhausted on either word
//  id_value           out  32  last captured ID word
//  ts_value           out  32  last captured timestamp word
// BEHAVIOUR
//  Reset: all outputs 0; FSM goes to IDLE. If AUTO_START=1, go to RD_ID_REQ on the first cycle after reset deasserts.
//  Reset mid-sequence: avm_read drops at the same edge; captured values and flags are cleared.
//  States: IDLE, RD_ID_REQ, RD_ID_WAIT, RD_TS_REQ, RD_TS_WAIT, CHECK, DONE.
//  IDLE/DONE + start -> RD_ID_REQ. At the same edge clear done, id_ok, ts_ok, timeout_err; busy=1.
//  start while busy is ignored.
//  *_REQ: avm_read=1 with avm_address held stable (0 for ID, 1 for TS) until waitrequest=0.
//    The accept edge moves the FSM to the matching *_WAIT state.
//  readdatavalid is honoured in the accept cycle of *_REQ (zero-latency slave) and in *_WAIT.
//    A beat in the *_REQ accept cycle captures data and skips *_WAIT.
//  readdatavalid in any other state is ignored.
//  Capture: the ID beat loads id_value -> RD_TS_REQ; the TS beat loads ts_value -> CHECK.
//  Timeout: a 16-bit counter clears on entry to *_REQ and increments each cycle in *_REQ/*_WAIT.
//    On count == TIMEOUT_CYCLES: drop avm_read, increment the retry count, re-enter the same *_REQ.
//    Once the retry count exceeds MAX_RETRIES: set timeout_err, go to DONE.
//    In that case id_ok and ts_ok stay 0.
//  The retry counter resets per word, on entry to RD_ID_REQ and to RD_TS_REQ.
//  CHECK (1 cycle): id_ok=(id_value==EXPECTED_ID), ts_ok=(ts_value==EXPECTED_TIMESTAMP) -> DONE.
//  DONE: busy=0, done=1. Flags and values are held until the next start.
//  Latency with a zero-wait, zero-latency slave: start -> done = 4 cycles.
//  At most one read is outstanding at a time; no pipelined reads are issued.
// STRUCTURE
//  Package nios_system_sysid_pkg holds:
//    sysid_state_t enum
//    SYSID_ADDR_ID = 1'b0 and SYSID_ADDR_TS = 1'b1
//    default EXPECTED_* constants
//  Sub-module nios_system_sysid_timer: loadable 16-bit timeout counter with a terminal-count output.
//    The FSM, capture registers and compare logic stay in the top module.
// TESTING
//  1. Zero-wait slave returns 0 then 1524171360; pulse start.
//     -> done at start+4; id_ok=1, ts_ok=1, timeout_err=0.
//  2. Slave returns 0 then 32'h12345678.
//     -> id_ok=1, ts_ok=0, ts_value=32'h12345678.
//  3. waitrequest held 3 cycles, readdatavalid 2 cycles after accept.
//     -> avm_address and avm_read stable while stalled; both words captured correctly.
//  4. Slave never asserts readdatavalid for address 1, TIMEOUT_CYCLES=8.
//     -> 4 attempts at address 1, then timeout_err=1, done=1, id_ok=0, ts_ok=0.
//  5. Assert reset during RD_TS_WAIT, then release with AUTO_START=1.
//     -> all outputs 0 during reset; a fresh sequence completes with pass flags.
//  6. start pulsed while busy, then again after done.
//     -> the first pulse is ignored; the second clears done at the same edge and reruns.

Source files
------------

// File: rtl/nios_system_sysid_pkg.sv
// Shared types and constants for the system ID checker: FSM states, slave word
// addresses and the default build identity the checker compares against.
package nios_system_sysid_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        RD_ID_REQ  = 3'd1,
        RD_ID_WAIT = 3'd2,
        RD_TS_REQ  = 3'd3,
        RD_TS_WAIT = 3'd4,
        CHECK      = 3'd5,
        DONE       = 3'd6
    } sysid_state_t;

    localparam logic SYSID_ADDR_ID = 1'b0;
    localparam logic SYSID_ADDR_TS = 1'b1;

    localparam logic [31:0] DEFAULT_EXPECTED_ID        = 32'd0;
    localparam logic [31:0] DEFAULT_EXPECTED_TIMESTAMP = 32'd1524171360;

    function automatic logic is_busy_state(input sysid_state_t s);
        return (s != IDLE) && (s != DONE);
    endfunction

endpackage

// File: rtl/nios_system_sysid_timer.sv
// Per-read timeout counter: cleared by load, counts while enabled and holds at
// LIMIT so the terminal count stays asserted until the next load.
module nios_system_sysid_timer #(
    parameter logic [15:0] LIMIT = 16'd255
) (
    input  logic clock,
    input  logic reset,
    input  logic load,
    input  logic en,
    output logic tc
);

    logic [15:0] count;

    always_ff @(posedge clock) begin
        if (reset || load) begin
            count <= 16'd0;
        end else if (en && !tc) begin
            count <= count + 16'd1;
        end
    end

    assign tc = (count == LIMIT);

endmodule

// File: rtl/nios_system_sysid_checker.sv
// Avalon-MM read master that fetches the sysid ID and timestamp words, compares
// them with the expected build identity and reports pass/fail/timeout status.
module nios_system_sysid_checker
    import nios_system_sysid_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID        = DEFAULT_EXPECTED_ID,
    parameter logic [31:0] EXPECTED_TIMESTAMP = DEFAULT_EXPECTED_TIMESTAMP,
    parameter logic [15:0] TIMEOUT_CYCLES     = 16'd255,
    parameter logic [1:0]  MAX_RETRIES        = 2'd3,
    parameter logic        AUTO_START         = 1'b1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    output logic         avm_address,
    output logic         avm_read,
    input  logic         avm_waitrequest,
    input  logic [31:0]  avm_readdata,
    input  logic         avm_readdatavalid,
    output logic         busy,
    output logic         done,
    output logic         id_ok,
    output logic         ts_ok,
    output logic         timeout_err,
    output logic [31:0]  id_value,
    output logic [31:0]  ts_value,
    output sysid_state_t state_dbg
);

    sysid_state_t state, state_next;
    logic         auto_pending;
    logic [1:0]   retry_cnt;
    logic         timer_load, timer_en, timer_tc;
    logic         cap_id, cap_ts, do_check, set_timeout, clear_flags;
    logic         retry_clr, retry_inc;
    logic         rd_ts, in_req;

    nios_system_sysid_timer #(.LIMIT(TIMEOUT_CYCLES)) u_timer (
        .clock (clock),
        .reset (reset),
        .load  (timer_load),
        .en    (timer_en),
        .tc    (timer_tc)
    );

    always_comb begin
        state_next  = state;
        timer_load  = 1'b0;
        timer_en    = 1'b0;
        cap_id      = 1'b0;
        cap_ts      = 1'b0;
        do_check    = 1'b0;
        set_timeout = 1'b0;
        clear_flags = 1'b0;
        retry_clr   = 1'b0;
        retry_inc   = 1'b0;
        avm_read    = 1'b0;
        avm_address = SYSID_ADDR_ID;
        rd_ts       = 1'b0;
        in_req      = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start || auto_pending) begin
                    state_next  = RD_ID_REQ;
                    clear_flags = 1'b1;
                    timer_load  = 1'b1;
                    retry_clr   = 1'b1;
                end
            end
            RD_ID_REQ, RD_ID_WAIT, RD_TS_REQ, RD_TS_WAIT: begin
                rd_ts       = (state == RD_TS_REQ) || (state == RD_TS_WAIT);
                in_req      = (state == RD_ID_REQ) || (state == RD_TS_REQ);
                timer_en    = 1'b1;
                avm_address = rd_ts ? SYSID_ADDR_TS : SYSID_ADDR_ID;
                // The timeout cycle deasserts read so the retry is a fresh request.
                avm_read    = in_req && !timer_tc;
                if (timer_tc) begin
                    if (retry_cnt == MAX_RETRIES) begin
                        set_timeout = 1'b1;
                        state_next  = DONE;
                    end else begin
                        retry_inc  = 1'b1;
                        timer_load = 1'b1;
                        state_next = rd_ts ? RD_TS_REQ : RD_ID_REQ;
                    end
                end else if (in_req && avm_waitrequest) begin
                    state_next = state;
                end else if (avm_readdatavalid) begin
                    cap_id = !rd_ts;
                    cap_ts = rd_ts;
                    if (rd_ts) begin
                        state_next = CHECK;
                    end else begin
                        state_next = RD_TS_REQ;
                        timer_load = 1'b1;
                        retry_clr  = 1'b1;
                    end
                end else if (in_req) begin
                    state_next = rd_ts ? RD_TS_WAIT : RD_ID_WAIT;
                end
            end
            CHECK: begin
                do_check   = 1'b1;
                state_next = DONE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            auto_pending <= AUTO_START;
            retry_cnt    <= 2'd0;
            id_value     <= 32'd0;
            ts_value     <= 32'd0;
            id_ok        <= 1'b0;
            ts_ok        <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            state <= state_next;
            if (clear_flags) begin
                auto_pending <= 1'b0;
                id_ok        <= 1'b0;
                ts_ok        <= 1'b0;
                timeout_err  <= 1'b0;
            end
            if (retry_clr) begin
                retry_cnt <= 2'd0;
            end else if (retry_inc) begin
                retry_cnt <= retry_cnt + 2'd1;
            end
            if (cap_id) id_value <= avm_readdata;
            if (cap_ts) ts_value <= avm_readdata;
            if (do_check) begin
                id_ok <= (id_value == EXPECTED_ID);
                ts_ok <= (ts_value == EXPECTED_TIMESTAMP);
            end
            if (set_timeout) timeout_err <= 1'b1;
        end
    end

    assign busy      = is_busy_state(state);
    assign done      = (state == DONE);
    assign state_dbg = state;

endmodule

// File: tb/tb_nios_system_sysid_checker.sv
// Bench for the sysid checker: a configurable Avalon sysid slave model, directed
// sequences with hand-computed results, and a done-triggered scoreboard monitor.
module tb_nios_system_sysid_checker;
    import nios_system_sysid_pkg::*;

    localparam logic [31:0] TS_GOOD = 32'd1524171360;
    localparam int W = 67;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic         avm_address, avm_read, avm_waitrequest, avm_readdatavalid;
    logic [31:0]  avm_readdata;
    logic         busy, done, id_ok, ts_ok, timeout_err;
    logic [31:0]  id_value, ts_value;
    sysid_state_t state_dbg;

    // slave model configuration
    logic [31:0] id_data = 32'd0;
    logic [31:0] ts_data = TS_GOOD;
    int          wait_cycles = 0;
    int          lat = 0;
    logic        ts_silent = 1'b0;

    int          stall_cnt = 0;
    int          pend_cnt = 0;
    logic        pend_addr = 1'b0;
    logic        responds;

    logic [W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int ts_attempts = 0;
    logic done_prev = 1'b0;
    logic stall_prev = 1'b0;
    logic stall_addr = 1'b0;

    nios_system_sysid_checker #(
        .TIMEOUT_CYCLES (16'd8),
        .AUTO_START     (1'b1)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .start             (start),
        .avm_address       (avm_address),
        .avm_read          (avm_read),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdata      (avm_readdata),
        .avm_readdatavalid (avm_readdatavalid),
        .busy              (busy),
        .done              (done),
        .id_ok             (id_ok),
        .ts_ok             (ts_ok),
        .timeout_err       (timeout_err),
        .id_value          (id_value),
        .ts_value          (ts_value),
        .state_dbg         (state_dbg)
    );

    // clock / reset
    always #5 clock = ~clock;

    // sysid slave model
    assign responds        = !(ts_silent && avm_address);
    assign avm_waitrequest = avm_read && (stall_cnt < wait_cycles);
    assign avm_readdatavalid = (avm_read && !avm_waitrequest && lat == 0 && responds) ||
                               (pend_cnt == 1);
    assign avm_readdata = (pend_cnt == 1) ? (pend_addr ? ts_data : id_data)
                                          : (avm_address ? ts_data : id_data);

    always @(posedge clock) begin
        if (!avm_read || !avm_waitrequest) stall_cnt <= 0;
        else stall_cnt <= stall_cnt + 1;
        if (reset) begin
            pend_cnt <= 0;
        end else if (pend_cnt != 0) begin
            pend_cnt <= pend_cnt - 1;
        end else if (avm_read && !avm_waitrequest && lat != 0 && responds) begin
            pend_cnt  <= lat;
            pend_addr <= avm_address;
        end
    end

    function automatic logic [W-1:0] pack(input logic iok, input logic tok, input logic to,
                                          input logic [31:0] iv, input logic [31:0] tv);
        return {iok, tok, to, iv, tv};
    endfunction

    task automatic check_eq(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // scoreboard monitor: pops one expectation per completed sequence
    always @(negedge clock) begin
        done_prev <= done;
        if (done && !done_prev && !reset) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: got result %h with no expectation queued",
                         pack(id_ok, ts_ok, timeout_err, id_value, ts_value));
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                if (pack(id_ok, ts_ok, timeout_err, id_value, ts_value) !== e) begin
                    errors++;
                    $display("FAIL result: got %h expected %h",
                             pack(id_ok, ts_ok, timeout_err, id_value, ts_value), e);
                end
            end
        end
    end

    // request stability while stalled, and accepted timestamp request count
    always @(negedge clock) begin
        stall_prev <= avm_read && avm_waitrequest && !reset;
        stall_addr <= avm_address;
        if (stall_prev && !reset) begin
            checks++;
            if (!(avm_read && avm_address == stall_addr)) begin
                errors++;
                $display("FAIL stall_hold: got read=%b addr=%b expected read=1 addr=%b",
                         avm_read, avm_address, stall_addr);
            end
        end
        if (avm_read && !avm_waitrequest && avm_address) ts_attempts <= ts_attempts + 1;
    end

    // driver tasks
    task automatic pulse_start();
        @(negedge clock); start = 1'b1;
        @(negedge clock); start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int max_cycles);
        int n;
        n = 0;
        while (!done && n < max_cycles) begin
            @(negedge clock);
            n++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got done=0 after %0d cycles expected done=1", name, n);
        end
    endtask

    task automatic run_timed(input string name);
        int n;
        pulse_start();
        check_eq({name, "_done_clear"}, W'(done), W'(0));
        n = 1;
        while (!done && n < 20) begin
            @(negedge clock);
            n++;
        end
        check_eq({name, "_latency"}, W'(n), W'(4));
    endtask

    task automatic check_all_zero(input string name);
        check_eq(name, W'({avm_address, avm_read, busy, done, id_ok, ts_ok, timeout_err,
                           state_dbg, id_value, ts_value}), W'(0));
    endtask

    initial begin
        int base;
        int n;
        // reset state, then the automatic sequence
        repeat (3) @(negedge clock);
        check_all_zero("reset_state");
        exp_q.push_back(pack(1'b1, 1'b1, 1'b0, 32'd0, TS_GOOD));
        reset = 1'b0;
        wait_done("auto_start", 20);

        // 1: zero-wait, zero-latency pass with latency check
        exp_q.push_back(pack(1'b1, 1'b1, 1'b0, 32'd0, TS_GOOD));
        run_timed("t1");

        // 2: timestamp mismatch
        ts_data = 32'h12345678;
        exp_q.push_back(pack(1'b1, 1'b0, 1'b0, 32'd0, 32'h12345678));
        pulse_start();
        wait_done("t2", 20);

        // 3: 3-cycle stall, data 2 cycles after accept
        ts_data = TS_GOOD;
        wait_cycles = 3;
        lat = 2;
        exp_q.push_back(pack(1'b1, 1'b1, 1'b0, 32'd0, TS_GOOD));
        pulse_start();
        wait_done("t3", 40);

        // 4: timestamp never answered; ts_value keeps the previous capture
        wait_cycles = 0;
        lat = 0;
        ts_silent = 1'b1;
        base = ts_attempts;
        exp_q.push_back(pack(1'b0, 1'b0, 1'b1, 32'd0, TS_GOOD));
        pulse_start();
        wait_done("t4", 200);
        @(negedge clock);
        check_eq("t4_ts_attempts", W'(ts_attempts - base), W'(4));

        // 5: reset in RD_TS_WAIT, then automatic rerun
        ts_silent = 1'b0;
        lat = 2;
        pulse_start();
        n = 0;
        while (state_dbg != RD_TS_WAIT && n < 50) begin
            @(negedge clock);
            n++;
        end
        check_eq("t5_reach_ts_wait", W'(state_dbg), W'(RD_TS_WAIT));
        reset = 1'b1;
        @(negedge clock);
        check_all_zero("t5_reset_edge");
        @(negedge clock);
        check_all_zero("t5_reset_hold");
        exp_q.push_back(pack(1'b1, 1'b1, 1'b0, 32'd0, TS_GOOD));
        reset = 1'b0;
        wait_done("t5", 40);

        // 6: start while busy is ignored; start after done reruns
        lat = 0;
        exp_q.push_back(pack(1'b1, 1'b1, 1'b0, 32'd0, TS_GOOD));
        pulse_start();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        wait_done("t6a", 20);
        repeat (3) @(negedge clock);
        check_eq("t6_no_rerun", W'({busy, done}), W'(2'b01));
        ts_data = 32'h0BADF00D;
        exp_q.push_back(pack(1'b1, 1'b0, 1'b0, 32'd0, 32'h0BADF00D));
        run_timed("t6b");

        repeat (3) @(negedge clock);
        check_eq("queue_drained", W'(exp_q.size()), W'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
